// File: rtl/mem_access_unit.sv
// Load/store sequencer between a pipeline and a byte-addressed data memory.
// Checks alignment, drives one memory access per request and extends load data.
module mem_access_unit #(
  parameter int NB_ADDR      = 7,
  parameter int NB_DATA      = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_write,
  input  logic [1:0]         i_req_size,
  input  logic               i_req_unsigned,
  input  logic [NB_ADDR-1:0] i_req_addr,
  input  logic [NB_DATA-1:0] i_req_wdata,
  output logic               o_resp_valid,
  output logic [NB_DATA-1:0] o_resp_rdata,
  output logic               o_misaligned,
  output logic               o_stall,
  output logic               o_mem_write_flag,
  output logic               o_mem_read_flag,
  output logic               o_word_enable,
  output logic               o_halfword_enable,
  output logic               o_byte_enable,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_DATA-1:0] o_mem_wdata,
  input  logic [NB_DATA-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       uns;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q, req_d;
  logic [1:0] cnt, cnt_d;

  logic               wf_d, rf_d, rv_d, mis_d;
  logic [2:0]         en_d, req_en;
  logic [NB_DATA-1:0] rdata_d, rdata_ext;
  logic [NB_ADDR-1:0] addr_d;
  logic [NB_DATA-1:0] wdata_d;
  logic               accept, req_mis, sgn;

  assign accept  = i_req_valid && (state == IDLE);
  assign req_mis = (i_req_size == 2'b11) ||
                   (i_req_size == 2'b01 && i_req_addr[0]) ||
                   (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00);

  // {word, halfword, byte} one-hot enable for a legal size
  always_comb begin
    req_en = 3'b000;
    case (i_req_size)
      2'b00:   req_en = 3'b001;
      2'b01:   req_en = 3'b010;
      2'b10:   req_en = 3'b100;
      default: req_en = 3'b000;
    endcase
  end

  always_comb begin
    sgn       = 1'b0;
    rdata_ext = i_mem_rdata;
    case (req_q.size)
      2'b00: begin
        sgn       = ~req_q.uns & i_mem_rdata[7];
        rdata_ext = {{(NB_DATA-8){sgn}}, i_mem_rdata[7:0]};
      end
      2'b01: begin
        sgn       = ~req_q.uns & i_mem_rdata[15];
        rdata_ext = {{(NB_DATA-16){sgn}}, i_mem_rdata[15:0]};
      end
      default: rdata_ext = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = req_mis ? RESP : (i_req_write ? WRITE : READ);
      WRITE: state_nxt = RESP;
      READ:  if (cnt == 2'd0) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; the read flag stays up while cnt counts down
  always_comb begin
    wf_d    = 1'b0;
    rf_d    = 1'b0;
    en_d    = 3'b000;
    rv_d    = 1'b0;
    mis_d   = 1'b0;
    rdata_d = '0;
    cnt_d   = cnt;
    req_d   = req_q;
    addr_d  = o_mem_addr;
    wdata_d = o_mem_wdata;
    case (state)
      IDLE: if (accept) begin
        req_d   = '{write: i_req_write, size: i_req_size, uns: i_req_unsigned};
        addr_d  = i_req_addr;
        wdata_d = i_req_wdata;
        if (req_mis) begin
          rv_d  = 1'b1;
          mis_d = 1'b1;
        end else if (i_req_write) begin
          wf_d = 1'b1;
          en_d = req_en;
        end else begin
          rf_d  = 1'b1;
          en_d  = req_en;
          cnt_d = 2'(READ_LATENCY - 1);
        end
      end
      WRITE: rv_d = 1'b1;
      READ: begin
        if (cnt == 2'd0) begin
          rv_d    = 1'b1;
          rdata_d = rdata_ext;
        end else begin
          rf_d  = 1'b1;
          en_d  = {o_word_enable, o_halfword_enable, o_byte_enable};
          cnt_d = cnt - 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      req_q             <= '0;
      cnt               <= 2'd0;
      o_mem_write_flag  <= 1'b0;
      o_mem_read_flag   <= 1'b0;
      o_word_enable     <= 1'b0;
      o_halfword_enable <= 1'b0;
      o_byte_enable     <= 1'b0;
      o_resp_valid      <= 1'b0;
      o_misaligned      <= 1'b0;
      o_resp_rdata      <= '0;
      o_mem_addr        <= '0;
      o_mem_wdata       <= '0;
    end else begin
      req_q             <= req_d;
      cnt               <= cnt_d;
      o_mem_write_flag  <= wf_d;
      o_mem_read_flag   <= rf_d;
      o_word_enable     <= en_d[2];
      o_halfword_enable <= en_d[1];
      o_byte_enable     <= en_d[0];
      o_resp_valid      <= rv_d;
      o_misaligned      <= mis_d;
      o_resp_rdata      <= rdata_d;
      o_mem_addr        <= addr_d;
      o_mem_wdata       <= wdata_d;
    end
  end

  assign o_req_ready = (state == IDLE);
  assign o_stall     = (state != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory behind the port, reference model
// of memory contents and per-request timing, directed plus random requests.
module tb_mem_access_unit;
  localparam int NA = 7;
  localparam int ND = 32;
  localparam int RL = 2;

  logic          i_clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_write = 1'b0;
  logic [1:0]    i_req_size = 2'b00;
  logic          i_req_unsigned = 1'b0;
  logic [NA-1:0] i_req_addr = '0;
  logic [ND-1:0] i_req_wdata = '0;
  logic          o_resp_valid;
  logic [ND-1:0] o_resp_rdata;
  logic          o_misaligned;
  logic          o_stall;
  logic          o_mem_write_flag;
  logic          o_mem_read_flag;
  logic          o_word_enable;
  logic          o_halfword_enable;
  logic          o_byte_enable;
  logic [NA-1:0] o_mem_addr;
  logic [ND-1:0] o_mem_wdata;
  logic [ND-1:0] i_mem_rdata;

  always #5 i_clock = ~i_clock;

  mem_access_unit #(.NB_ADDR(NA), .NB_DATA(ND), .READ_LATENCY(RL)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .o_resp_valid(o_resp_valid),
    .o_resp_rdata(o_resp_rdata), .o_misaligned(o_misaligned),
    .o_stall(o_stall), .o_mem_write_flag(o_mem_write_flag),
    .o_mem_read_flag(o_mem_read_flag), .o_word_enable(o_word_enable),
    .o_halfword_enable(o_halfword_enable), .o_byte_enable(o_byte_enable),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  // Memory seen by the DUT; data is only valid on the RL-th read-flag cycle
  logic [7:0]  phys_mem [0:127];
  logic [7:0]  ref_mem  [0:127];
  int          rd_cycles = 0;
  logic [31:0] mem_word;

  always @(posedge i_clock) begin
    if (o_mem_write_flag) begin
      phys_mem[o_mem_addr] <= o_mem_wdata[7:0];
      if (o_halfword_enable || o_word_enable) phys_mem[o_mem_addr + 7'd1] <= o_mem_wdata[15:8];
      if (o_word_enable) begin
        phys_mem[o_mem_addr + 7'd2] <= o_mem_wdata[23:16];
        phys_mem[o_mem_addr + 7'd3] <= o_mem_wdata[31:24];
      end
    end
    rd_cycles <= o_mem_read_flag ? rd_cycles + 1 : 0;
  end

  always_comb begin
    mem_word = {phys_mem[o_mem_addr + 7'd3], phys_mem[o_mem_addr + 7'd2],
                phys_mem[o_mem_addr + 7'd1], phys_mem[o_mem_addr]};
    i_mem_rdata = 32'hDEADBEEF;
    if (o_mem_read_flag && rd_cycles == RL - 1) begin
      if (o_word_enable)          i_mem_rdata = mem_word;
      else if (o_halfword_enable) i_mem_rdata = {16'hA5C3, mem_word[15:0]};
      else if (o_byte_enable)     i_mem_rdata = {24'h5AA55A, mem_word[7:0]};
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [6:0] a);
    longint unsigned v;
    int nb;
    v  = 0;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) v |= longint'(ref_mem[(int'(a) + i) % 128]) << (8 * i);
    if (!uns && ((v >> (8 * nb - 1)) & 1) == 1) v |= (~64'd0) << (8 * nb);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [6:0] a, input logic [31:0] wd);
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) ref_mem[(int'(a) + i) % 128] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // Issue one request from a negedge and check every cycle until back in IDLE
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [6:0] a, input logic [31:0] wd, output logic [31:0] rd_obs);
    logic mis, wf_e, rf_e;
    int resp_k, w;
    logic [2:0] en_exp;
    logic [31:0] exp_rd;
    mis    = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    en_exp = (sz == 2'b00) ? 3'b001 : (sz == 2'b01) ? 3'b010 : 3'b100;
    resp_k = mis ? 1 : (wr ? 2 : RL + 1);
    exp_rd = (mis || wr) ? 32'd0 : model_load(sz, uns, a);
    w = 0;
    while (!o_req_ready && w < 16) begin @(negedge i_clock); w++; end
    check("ready_before_req", 64'(o_req_ready), 64'd1);
    i_req_valid = 1'b1; i_req_write = wr; i_req_size = sz;
    i_req_unsigned = uns; i_req_addr = a; i_req_wdata = wd;
    @(posedge i_clock);
    #1 i_req_valid = 1'b0;
    if (wr && !mis) model_store(sz, a, wd);
    rd_obs = '0;
    for (int k = 1; k <= resp_k + 1; k++) begin
      @(negedge i_clock);
      wf_e = wr && !mis && k == 1;
      rf_e = !wr && !mis && k <= RL;
      check("flag_overlap", 64'(o_mem_write_flag & o_mem_read_flag), 64'd0);
      check("write_flag", 64'(o_mem_write_flag), 64'(wf_e));
      check("read_flag", 64'(o_mem_read_flag), 64'(rf_e));
      check("enables", 64'({o_word_enable, o_halfword_enable, o_byte_enable}),
            64'((wf_e || rf_e) ? en_exp : 3'b000));
      check("resp_valid", 64'(o_resp_valid), 64'(k == resp_k));
      check("misaligned", 64'(o_misaligned), 64'((k == resp_k) && mis));
      if (k == resp_k) rd_obs = o_resp_rdata;
      check("resp_rdata", 64'(o_resp_rdata), 64'((k == resp_k) ? exp_rd : 32'd0));
      check("req_ready", 64'(o_req_ready), 64'(k == resp_k + 1));
      check("stall", 64'(o_stall), 64'(k != resp_k + 1));
      if (k <= resp_k) begin
        check("mem_addr_hold", 64'(o_mem_addr), 64'(a));
        check("mem_wdata_hold", 64'(o_mem_wdata), 64'(wd));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic wr, uns;
    logic [1:0] sz;
    logic [6:0] a;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;

    #3;
    check("rst_ready", 64'(o_req_ready), 64'd1);
    check("rst_stall", 64'(o_stall), 64'd0);
    check("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    check("rst_flags", 64'({o_mem_write_flag, o_mem_read_flag}), 64'd0);
    check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    @(negedge i_clock); @(negedge i_clock);
    i_reset_n = 1'b1;
    @(negedge i_clock);

    for (int i = 0; i < 32; i++) do_req(1'b1, 2'b10, 1'b0, 7'(i * 4), $urandom, r);

    do_req(1'b1, 2'b10, 1'b0, 7'd0, 32'hFFFFFFFF, r);
    do_req(1'b1, 2'b00, 1'b0, 7'd0, 32'h00000000, r);
    do_req(1'b0, 2'b00, 1'b0, 7'd0, 32'h0, r);
    check("spec_byte0_signed", 64'(r), 64'h00000000);
    do_req(1'b1, 2'b00, 1'b0, 7'd3, 32'h00000080, r);
    do_req(1'b0, 2'b00, 1'b0, 7'd3, 32'h0, r);
    check("spec_byte80_signed", 64'(r), 64'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 7'd3, 32'h0, r);
    check("spec_byte80_unsigned", 64'(r), 64'h00000080);
    do_req(1'b1, 2'b01, 1'b0, 7'd10, 32'h0000FFFF, r);
    do_req(1'b0, 2'b01, 1'b0, 7'd10, 32'h0, r);
    check("spec_half_signed", 64'(r), 64'hFFFFFFFF);
    do_req(1'b0, 2'b10, 1'b0, 7'd6, 32'h0, r);
    check("spec_mis_word", 64'(r), 64'h0);
    do_req(1'b0, 2'b01, 1'b0, 7'd5, 32'h0, r);
    check("spec_mis_half", 64'(r), 64'h0);
    do_req(1'b1, 2'b11, 1'b0, 7'd0, 32'h12345678, r);
    check("spec_mis_size3", 64'(r), 64'h0);

    // Reset in the middle of a read aborts it
    i_req_valid = 1'b1; i_req_write = 1'b0; i_req_size = 2'b10; i_req_addr = 7'd8;
    @(posedge i_clock);
    #1 i_req_valid = 1'b0;
    @(negedge i_clock);
    check("abort_pre_read_flag", 64'(o_mem_read_flag), 64'd1);
    #2 i_reset_n = 1'b0;
    #1;
    check("abort_flags", 64'({o_mem_write_flag, o_mem_read_flag}), 64'd0);
    check("abort_enables", 64'({o_word_enable, o_halfword_enable, o_byte_enable}), 64'd0);
    check("abort_ready", 64'(o_req_ready), 64'd1);
    check("abort_stall", 64'(o_stall), 64'd0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clock);
      check("abort_no_resp", 64'(o_resp_valid), 64'd0);
      check("abort_idle_flags", 64'({o_mem_write_flag, o_mem_read_flag}), 64'd0);
    end
    do_req(1'b0, 2'b10, 1'b1, 7'd8, 32'h0, r);

    // Valid held high across two stores: second accepted only once IDLE again
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_size = 2'b10;
    i_req_unsigned = 1'b0; i_req_addr = 7'd16; i_req_wdata = 32'hCAFEF00D;
    @(posedge i_clock);
    model_store(2'b10, 7'd16, 32'hCAFEF00D);
    for (int k = 1; k <= 7; k++) begin
      @(negedge i_clock);
      check("b2b_write_flag", 64'(o_mem_write_flag), 64'(k == 1 || k == 4));
      check("b2b_overlap", 64'(o_mem_write_flag & o_mem_read_flag), 64'd0);
      check("b2b_resp", 64'(o_resp_valid), 64'(k == 2 || k == 5));
      check("b2b_ready", 64'(o_req_ready), 64'(k == 3 || k >= 6));
      if (k == 1) begin
        check("b2b_addr_a", 64'(o_mem_addr), 64'd16);
        i_req_size = 2'b00; i_req_addr = 7'd21; i_req_wdata = 32'h0000005C;
      end
      if (k == 4) begin
        check("b2b_addr_b", 64'(o_mem_addr), 64'd21);
        i_req_valid = 1'b0;
        model_store(2'b00, 7'd21, 32'h0000005C);
      end
    end
    do_req(1'b0, 2'b10, 1'b0, 7'd20, 32'h0, r);

    for (int n = 0; n < 80; n++) begin
      wr  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'($urandom_range(0, 2));
      a = 7'($urandom_range(0, 127));
      if (sz != 2'b11 && $urandom_range(0, 9) < 7) a = a & ~7'((1 << sz) - 1);
      do_req(wr, sz, uns, a, $urandom, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
